// File: rtl/sumador_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package sumador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of digit cycles needed for one operation.
  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/sumador_digito.sv
// Combinational DIGIT-bit ripple adder; c_msb is the carry into the top bit.
module sumador_digito #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/sumador_serie_n.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB digit first, start/done handshake.
module sumador_serie_n
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Carry,
  output logic             Ovf,
  output logic             Zero
);

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             c;
  logic             op_q;

  logic [DIGIT-1:0] d_s;
  logic             d_co;
  logic             d_cmsb;
  logic [WIDTH-1:0] r_next;
  logic             last;

  sumador_digito #(
    .DIGIT(DIGIT)
  ) u_digito (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .ci   (c),
    .s    (d_s),
    .co   (d_co),
    .c_msb(d_cmsb)
  );

  // New digit enters at the MSB end so the result is aligned after NDIG shifts.
  assign r_next = (r_sr >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));
  assign last   = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      c     <= 1'b0;
      op_q  <= OP_ADD;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Carry <= 1'b0;
      Ovf   <= 1'b0;
      Zero  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction as A + ~B + ~borrow_in.
            a_sr  <= A;
            b_sr  <= (Op == OP_SUB) ? ~B : B;
            c     <= (Op == OP_SUB) ? ~Cin : Cin;
            op_q  <= Op;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          a_sr <= a_sr >> DIGIT;
          b_sr <= b_sr >> DIGIT;
          r_sr <= r_next;
          c    <= d_co;
          cnt  <= cnt + CW'(1);
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            S     <= r_next;
            Carry <= d_co ^ op_q;
            Ovf   <= d_cmsb ^ d_co;
            Zero  <= (r_next == '0);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serie_n.sv
// Directed self-checking bench for sumador_serie_n in three width/digit configurations.
module tb_sumador_serie_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start = 1'b0, Op = 1'b0, Cin = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic       busy, done, Carry, Ovf, Zero;
  logic [7:0] S;

  logic        start16 = 1'b0, Op16 = 1'b0, Cin16 = 1'b0;
  logic [15:0] A16 = '0, B16 = '0;
  logic        busy16, done16, Carry16, Ovf16, Zero16;
  logic [15:0] S16;

  logic       start1 = 1'b0, Op1 = 1'b0, Cin1 = 1'b0;
  logic [7:0] A1 = '0, B1 = '0;
  logic       busy1, done1, Carry1, Ovf1, Zero1;
  logic [7:0] S1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sumador_serie_n #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Op(Op), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .Carry(Carry), .Ovf(Ovf), .Zero(Zero)
  );

  sumador_serie_n #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .Op(Op16), .A(A16), .B(B16), .Cin(Cin16),
    .busy(busy16), .done(done16), .S(S16), .Carry(Carry16), .Ovf(Ovf16), .Zero(Zero16)
  );

  sumador_serie_n #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .Op(Op1), .A(A1), .B(B1), .Cin(Cin1),
    .busy(busy1), .done(done1), .S(S1), .Carry(Carry1), .Ovf(Ovf1), .Zero(Zero1)
  );

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation on the 8/2 instance; returns busy-cycle and done-pulse counts.
  task automatic do_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, output int busy_n, output int done_n);
    logic got;
    @(negedge clk);
    start = 1'b1; Op = op; A = a; B = b; Cin = cin;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; done_n = 0; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (busy) busy_n++;
      if (done) begin got = 1'b1; done_n++; end
      else @(negedge clk);
    end
    if (!got) $display("FAIL do_op_timeout: got no done expected done within 12 cycles");
    if (!got) n_fail++;
    @(negedge clk);
    if (done) done_n++;
  endtask

  initial begin
    int bn, dn, ndone, t0, t1, t2;
    logic [7:0] exp_s;

    vecs[0] = '{1'b0, 8'd10,  8'd5,  1'b0, 8'd15,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'd120, 8'd50, 1'b0, 8'hAA,  1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'd255, 8'd1,  1'b0, 8'h00,  1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'd50,  8'd25, 1'b1, 8'd24,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'd5,   8'd10, 1'b0, 8'hFB,  1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'h33,  8'h33, 1'b0, 8'h00,  1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 8'h7F,  8'h00, 1'b1, 8'h80,  1'b0, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_busy",  busy,  0);
    check("reset_done",  done,  0);
    check("reset_S",     S,     0);
    check("reset_Carry", Carry, 0);
    check("reset_Ovf",   Ovf,   0);
    check("reset_Zero",  Zero,  0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, bn, dn);
      check($sformatf("vec%0d_S", i),     S,     vecs[i].s);
      check($sformatf("vec%0d_Carry", i), Carry, vecs[i].c);
      check($sformatf("vec%0d_Ovf", i),   Ovf,   vecs[i].v);
      check($sformatf("vec%0d_Zero", i),  Zero,  vecs[i].z);
      check($sformatf("vec%0d_busy_cycles", i), bn, 4);
      check($sformatf("vec%0d_done_pulses", i), dn, 1);
    end

    // start pulsed mid-operation with other operands must be ignored
    @(negedge clk);
    start = 1'b1; Op = 1'b0; A = 8'd10; B = 8'd5; Cin = 1'b0;
    @(negedge clk);
    start = 1'b1; Op = 1'b1; A = 8'd200; B = 8'd100; Cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_S_during_busy", S, 8'h80);
    check("hold_Ovf_during_busy", Ovf, 1);
    ndone = 0;
    for (int i = 0; i < 12 && ndone == 0; i++) begin
      if (done) ndone++;
      else @(negedge clk);
    end
    check("ignore_start_done", ndone, 1);
    check("ignore_start_S", S, 15);
    check("ignore_start_Carry", Carry, 0);
    @(negedge clk);
    check("ignore_start_no_second", busy | done, 0);

    // asynchronous reset in busy cycle 2 aborts the operation
    @(negedge clk);
    start = 1'b1; Op = 1'b0; A = 8'd255; B = 8'd1; Cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy",  busy,  0);
    check("abort_done",  done,  0);
    check("abort_S",     S,     0);
    check("abort_Carry", Carry, 0);
    check("abort_Ovf",   Ovf,   0);
    check("abort_Zero",  Zero,  0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done | busy) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // start held high: three back-to-back operations, done every 6 cycles
    @(negedge clk);
    start = 1'b1; Op = 1'b0; A = 8'd3; B = 8'd4; Cin = 1'b0;
    ndone = 0; t0 = 0; t1 = 0; t2 = 0;
    for (int cyc = 0; cyc < 40 && ndone < 3; cyc++) begin
      @(negedge clk);
      if (done) begin
        exp_s = (ndone == 0) ? 8'd7 : (ndone == 1) ? 8'd104 : 8'd0;
        check($sformatf("b2b%0d_S", ndone), S, exp_s);
        if (ndone == 0) t0 = cyc;
        if (ndone == 1) t1 = cyc;
        if (ndone == 2) t2 = cyc;
        ndone++;
        if (ndone == 1) A = 8'd100;
        if (ndone == 2) A = 8'd252;
        if (ndone == 3) start = 1'b0;
      end
    end
    check("b2b_count", ndone, 3);
    check("b2b_gap1", t1 - t0, 6);
    check("b2b_gap2", t2 - t1, 6);
    check("b2b_last_Zero", Zero, 1);
    check("b2b_last_Carry", Carry, 1);

    // WIDTH=16, DIGIT=4: 0xFFFF + 1
    @(negedge clk);
    start16 = 1'b1; Op16 = 1'b0; A16 = 16'hFFFF; B16 = 16'h0001; Cin16 = 1'b0;
    @(negedge clk);
    start16 = 1'b0;
    bn = 0; ndone = 0;
    for (int i = 0; i < 12 && ndone == 0; i++) begin
      if (busy16) bn++;
      if (done16) ndone++;
      else @(negedge clk);
    end
    check("w16_done", ndone, 1);
    check("w16_busy_cycles", bn, 4);
    check("w16_S", S16, 0);
    check("w16_Carry", Carry16, 1);
    check("w16_Ovf", Ovf16, 0);
    check("w16_Zero", Zero16, 1);

    // WIDTH=8, DIGIT=1: 85 + 170
    @(negedge clk);
    start1 = 1'b1; Op1 = 1'b0; A1 = 8'd85; B1 = 8'd170; Cin1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    bn = 0; ndone = 0;
    for (int i = 0; i < 16 && ndone == 0; i++) begin
      if (busy1) bn++;
      if (done1) ndone++;
      else @(negedge clk);
    end
    check("d1_done", ndone, 1);
    check("d1_busy_cycles", bn, 8);
    check("d1_S", S1, 255);
    check("d1_Carry", Carry1, 0);
    check("d1_Ovf", Ovf1, 0);
    check("d1_Zero", Zero1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
